// File: rtl/ft232h_pkg.sv
// ---------------------------------------------------------------------------
// ft232h_pkg
// Shared constants for the ft232h TX DMA feeder and the byte unpacker:
//   - CSR word indices and the CONTROL / STATUS bit positions
//   - FSM state encoding (sized localparams so older tools accept them)
//   - ft232h bridge register map (WRITE_DATA register index)
// ---------------------------------------------------------------------------
package ft232h_pkg;

  // CSR word indices on csr_address
  localparam logic [1:0] CSR_SRC_ADDR = 2'd0;
  localparam logic [1:0] CSR_LENGTH   = 2'd1;
  localparam logic [1:0] CSR_CONTROL  = 2'd2;
  localparam logic [1:0] CSR_STATUS   = 2'd3;

  // CONTROL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits; the remaining-byte count occupies [31:16]
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // DMA FSM state encoding
  typedef logic [1:0] dma_state_t;
  localparam dma_state_t ST_IDLE = 2'd0;
  localparam dma_state_t ST_RD   = 2'd1;
  localparam dma_state_t ST_WR   = 2'd2;
  localparam dma_state_t ST_FIN  = 2'd3;

  // ft232h bridge register map
  localparam logic [7:0] BRIDGE_WRITE_DATA = 8'd1;

endpackage

// File: rtl/ft232h_byte_unpack.sv
// ---------------------------------------------------------------------------
// ft232h_byte_unpack
// Holds one fetched 32-bit word and walks through its bytes little-endian.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture word_in and restart at byte 0
//   word_in       word returned by the memory read
//   advance       current byte was accepted; step to the next one
//   remaining     bytes still to send in the transfer (current byte included)
//   byte_out      byte currently selected (index 0 = bits [7:0])
//   byte_wrap     current byte is byte 3 of the word
//   byte_last     current byte is the final byte of the transfer
// ---------------------------------------------------------------------------
module ft232h_byte_unpack #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      word_in,
  input  logic             advance,
  input  logic [LEN_W-1:0] remaining,
  output logic [7:0]       byte_out,
  output logic             byte_wrap,
  output logic             byte_last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = word_in;
      idx_d  = 2'd0;
    end else if (advance) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    byte_out = word_q[7:0];
      2'd1:    byte_out = word_q[15:8];
      2'd2:    byte_out = word_q[23:16];
      default: byte_out = word_q[31:24];
    endcase
  end

  assign byte_wrap = (idx_q == 2'd3);
  // The last byte is decided by the byte count, not the word position, so a
  // short final word simply stops early and its upper bytes are dropped.
  assign byte_last = (remaining == LEN_W'(1));

endmodule

// File: rtl/ft232h_tx_dma.sv
// ---------------------------------------------------------------------------
// ft232h_tx_dma
// Avalon-MM DMA feeder for the ft232h USB bridge: reads 32-bit words from
// memory, unpacks them little-endian and writes them byte by byte into the
// bridge WRITE_DATA register, honouring both waitrequests.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   csr_*                         CSR slave (SRC_ADDR, LENGTH, CONTROL, STATUS)
//   mem_address/read/readdata/
//   mem_waitrequest               Avalon-MM read master towards memory
//   ft_address/write/writedata/
//   ft_waitrequest                Avalon-MM write master towards the bridge
//   irq                           done interrupt (only with the macro below)
// Build option:
//   FT232H_TX_DMA_IRQ_EN  adds the irq port and the CONTROL.IRQ_EN bit.
// ---------------------------------------------------------------------------
module ft232h_tx_dma
  import ft232h_pkg::*;
#(
  parameter int         ADDR_W       = 32,
  parameter int         LEN_W        = 16,
  parameter logic [7:0] FT_DATA_ADDR = BRIDGE_WRITE_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [7:0]        ft_address,
  output logic              ft_write,
  output logic [31:0]       ft_writedata,
`ifdef FT232H_TX_DMA_IRQ_EN
  output logic              irq,
`endif
  input  logic              ft_waitrequest
);

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  length_q, length_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              abort_q, abort_d;
  logic              irq_en_q, irq_en_d;
  logic [31:0]       csr_rdata_q, csr_rdata_d;

  logic        busy, start_wr, abort_wr, abort_now;
  logic        mem_hs, ft_hs, set_done, set_aborted;
  logic [7:0]  cur_byte;
  logic        byte_wrap, byte_last;
  logic [31:0] status_word;

  assign busy      = (state_q != ST_IDLE);
  assign start_wr  = csr_write && (csr_address == CSR_CONTROL) && csr_writedata[CTRL_START];
  assign abort_wr  = csr_write && (csr_address == CSR_CONTROL) && csr_writedata[CTRL_ABORT];
  // An abort requested earlier, or arriving in the very cycle a handshake
  // completes, ends the transfer at that handshake.
  assign abort_now = abort_q || abort_wr;
  assign mem_hs    = (state_q == ST_RD) && !mem_waitrequest;
  assign ft_hs     = (state_q == ST_WR) && !ft_waitrequest;

  ft232h_byte_unpack #(.LEN_W(LEN_W)) u_unpack (
    .clk       (clk),
    .rst       (rst),
    .load      (mem_hs),
    .word_in   (mem_readdata),
    .advance   (ft_hs),
    .remaining (rem_q),
    .byte_out  (cur_byte),
    .byte_wrap (byte_wrap),
    .byte_last (byte_last)
  );

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = busy;
    status_word[STAT_DONE]    = done_q;
    status_word[STAT_ABORTED] = aborted_q;
    status_word[31:16]        = 16'(rem_q);
  end

  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    ptr_d       = ptr_q;
    length_d    = length_q;
    rem_d       = rem_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    abort_d     = abort_q;
    irq_en_d    = irq_en_q;
    csr_rdata_d = csr_rdata_q;
    set_done    = 1'b0;
    set_aborted = 1'b0;

    // CSR writes only touch the programming registers; the running transfer
    // works from its own pointer/counter copies.
    if (csr_write) begin
      case (csr_address)
        CSR_SRC_ADDR: src_addr_d = ADDR_W'(csr_writedata) & ~ADDR_W'(3);
        CSR_LENGTH:   length_d   = csr_writedata[LEN_W-1:0];
        CSR_CONTROL: begin
`ifdef FT232H_TX_DMA_IRQ_EN
          irq_en_d = csr_writedata[CTRL_IRQ_EN];
`else
          irq_en_d = 1'b0;
`endif
        end
        default: begin
          if (csr_writedata[STAT_DONE]) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
          end
        end
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_wr) begin
          ptr_d = src_addr_q;
          rem_d = length_q;
          if (length_q == '0) set_done = 1'b1;
          else                state_d  = ST_RD;
        end
      end
      ST_RD: begin
        if (abort_wr) abort_d = 1'b1;
        if (!mem_waitrequest) begin
          if (abort_now) begin
            state_d     = ST_IDLE;
            set_done    = 1'b1;
            set_aborted = 1'b1;
            abort_d     = 1'b0;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(4);
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (abort_wr) abort_d = 1'b1;
        if (!ft_waitrequest) begin
          rem_d = rem_q - LEN_W'(1);
          if (abort_now) begin
            state_d     = ST_IDLE;
            set_done    = 1'b1;
            set_aborted = 1'b1;
            abort_d     = 1'b0;
          end else if (byte_last) begin
            state_d = ST_FIN;
          end else if (byte_wrap) begin
            state_d = ST_RD;
          end
        end
      end
      default: begin
        set_done = 1'b1;
        abort_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Applied after the STATUS clear so a same-cycle set wins.
    if (set_done)    done_d    = 1'b1;
    if (set_aborted) aborted_d = 1'b1;

    if (csr_read) begin
      case (csr_address)
        CSR_SRC_ADDR: csr_rdata_d = 32'(src_addr_q);
        CSR_LENGTH:   csr_rdata_d = 32'(length_q);
        CSR_CONTROL:  csr_rdata_d = {29'd0, irq_en_q, 2'b00};
        default:      csr_rdata_d = status_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_addr_q  <= '0;
      ptr_q       <= '0;
      length_q    <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      abort_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      ptr_q       <= ptr_d;
      length_q    <= length_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      abort_q     <= abort_d;
      irq_en_q    <= irq_en_d;
      csr_rdata_q <= csr_rdata_d;
    end
  end

  // Bus requests come straight from the registered state, so they stay
  // asserted with stable address/data for as long as waitrequest is high.
  assign mem_read     = (state_q == ST_RD);
  assign mem_address  = ptr_q;
  assign ft_write     = (state_q == ST_WR);
  assign ft_writedata = ft_write ? {24'd0, cur_byte} : 32'd0;
  assign ft_address   = FT_DATA_ADDR;
  assign csr_readdata = csr_rdata_q;

`ifdef FT232H_TX_DMA_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

endmodule
